// File: rtl/imem_boot_loader.sv
// imem_boot_loader: instruction memory for the 5-stage core's fetch port.
// A program arrives as a byte stream: a 16-bit word count, the data words,
// then a checksum byte. The core is held in reset until a load completes
// with a matching checksum. Fetches are answered combinationally.
module imem_boot_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_instr,
  output logic        fetch_err,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] nWords_q, nWords_d;
  logic [15:0] wordIdx_q, wordIdx_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [23:0] wordBuf_q, wordBuf_d;
  logic [7:0]  sum_q, sum_d;
  logic        loadDone_q, loadDone_d;
  logic        loadErr_q, loadErr_d;
  logic [15:0] wordsLoaded_q, wordsLoaded_d;
  logic        coreRstN_q, coreRstN_d;

  logic          accept;
  logic [15:0]   lenFull;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [31:0]   memData;
  logic [31:0]   mem [DEPTH];

  logic [29:0]   fetchIdx;
  logic          fetchHit;

  assign ld_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CSUM);
  assign accept   = ld_valid && ld_ready && !ld_start;
  assign lenFull  = {ld_byte, nWords_q[7:0]};

  // Next-state, datapath and status updates; ld_start overrides any byte
  always_comb begin
    state_d       = state_q;
    nWords_d      = nWords_q;
    wordIdx_d     = wordIdx_q;
    byteCnt_d     = byteCnt_q;
    wordBuf_d     = wordBuf_q;
    sum_d         = sum_q;
    loadDone_d    = loadDone_q;
    loadErr_d     = loadErr_q;
    wordsLoaded_d = wordsLoaded_q;
    memWe         = 1'b0;
    memAddr       = wordIdx_q[AW-1:0];
    memData       = {ld_byte, wordBuf_q};

    if (ld_start) begin
      state_d    = LEN_LO;
      wordIdx_d  = 16'd0;
      byteCnt_d  = 2'd0;
      sum_d      = 8'd0;
      loadDone_d = 1'b0;
      loadErr_d  = 1'b0;
    end else if (accept) begin
      case (state_q)
        LEN_LO: begin
          nWords_d[7:0] = ld_byte;
          state_d       = LEN_HI;
        end
        LEN_HI: begin
          nWords_d[15:8] = ld_byte;
          if ({1'b0, lenFull} > DEPTH_W) begin
            state_d       = ERR;
            loadErr_d     = 1'b1;
            wordsLoaded_d = 16'd0;
          end else if (lenFull == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          sum_d     = sum_q + ld_byte;
          byteCnt_d = byteCnt_q + 2'd1;
          case (byteCnt_q)
            2'd0: wordBuf_d[7:0]   = ld_byte;
            2'd1: wordBuf_d[15:8]  = ld_byte;
            2'd2: wordBuf_d[23:16] = ld_byte;
            default: begin
              memWe     = 1'b1;
              wordIdx_d = wordIdx_q + 16'd1;
              if (wordIdx_q == nWords_q - 16'd1) begin
                state_d = CSUM;
              end
            end
          endcase
        end
        CSUM: begin
          if (ld_byte == sum_q) begin
            state_d       = DONE;
            loadDone_d    = 1'b1;
            wordsLoaded_d = nWords_q;
          end else begin
            state_d       = ERR;
            loadErr_d     = 1'b1;
            wordsLoaded_d = 16'd0;
          end
        end
        default: begin
        end
      endcase
    end

    coreRstN_d = (state_d == DONE);
  end

  // Control and status registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      nWords_q      <= 16'd0;
      wordIdx_q     <= 16'd0;
      byteCnt_q     <= 2'd0;
      wordBuf_q     <= 24'd0;
      sum_q         <= 8'd0;
      loadDone_q    <= 1'b0;
      loadErr_q     <= 1'b0;
      wordsLoaded_q <= 16'd0;
      coreRstN_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      nWords_q      <= nWords_d;
      wordIdx_q     <= wordIdx_d;
      byteCnt_q     <= byteCnt_d;
      wordBuf_q     <= wordBuf_d;
      sum_q         <= sum_d;
      loadDone_q    <= loadDone_d;
      loadErr_q     <= loadErr_d;
      wordsLoaded_q <= wordsLoaded_d;
      coreRstN_q    <= coreRstN_d;
    end
  end

  // Instruction storage; contents survive reset and are gated by words_loaded
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  assign fetchIdx = fetch_addr[31:2];
  assign fetchHit = loadDone_q && (fetch_addr[1:0] == 2'b00) &&
                    (fetchIdx < {14'd0, wordsLoaded_q});

  assign fetch_instr  = fetchHit ? mem[fetchIdx[AW-1:0]] : NOP;
  assign fetch_err    = !fetchHit;
  assign core_rst_n   = coreRstN_q;
  assign load_done    = loadDone_q;
  assign load_err     = loadErr_q;
  assign words_loaded = wordsLoaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: drives load streams, then probes the
// fetch port against expectations queued when each probe is issued.
module tb_imem_boot_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_err;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } fetchExp_t;

  fetchExp_t   scoreboard[$];
  logic [31:0] progWords[$];

  imem_boot_loader #(.DEPTH(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_ready     (ld_ready),
    .fetch_addr   (fetch_addr),
    .fetch_instr  (fetch_instr),
    .fetch_err    (fetch_err),
    .core_rst_n   (core_rst_n),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls outside the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h required=%h", tag, observed, expected);
    end
  endtask

  // Offer one byte and hold it until accepted, bounded by a cycle budget
  task automatic applyStimulus(input logic [7:0] b);
    bit taken = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = b;
    for (int i = 0; i < 20 && !taken; i++) begin
      if (ld_ready) taken = 1'b1;
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    if (!taken) checkOutput("readyTimeout", 32'd0, 32'd1);
  endtask

  task automatic pulseStart();
    ld_start = 1'b1;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
  endtask

  // Queue the expected fetch result, drive the address, then pop and compare
  task automatic probeFetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] expInstr, input logic expErr);
    fetchExp_t e;
    fetchExp_t got;
    e.instr = expInstr;
    e.err   = expErr;
    scoreboard.push_back(e);
    fetch_addr = addr;
    #2;
    got = scoreboard.pop_front();
    checkOutput({tag, "_instr"}, fetch_instr, got.instr);
    checkOutput({tag, "_err"}, {31'd0, fetch_err}, {31'd0, got.err});
  endtask

  // Full load of progWords with the checksum offset by csumDelta
  task automatic loadProgram(input logic [7:0] csumDelta);
    logic [7:0]  sum = 8'd0;
    logic [31:0] w;
    logic [15:0] n;
    n = 16'(progWords.size());
    pulseStart();
    applyStimulus(n[7:0]);
    applyStimulus(n[15:8]);
    foreach (progWords[k]) begin
      w = progWords[k];
      for (int j = 0; j < 4; j++) begin
        applyStimulus(w[8*j +: 8]);
        sum = sum + w[8*j +: 8];
      end
    end
    checkOutput("coreRstBeforeCsum", {31'd0, core_rst_n}, 32'd0);
    applyStimulus(sum + csumDelta);
  endtask

  task automatic checkResetValues(input string tag);
    fetch_addr = 32'd0;
    #1;
    checkOutput({tag, "_ready"}, {31'd0, ld_ready}, 32'd0);
    checkOutput({tag, "_coreRst"}, {31'd0, core_rst_n}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, load_done}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, load_err}, 32'd0);
    checkOutput({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
    checkOutput({tag, "_fetchErr"}, {31'd0, fetch_err}, 32'd1);
    checkOutput({tag, "_fetchInstr"}, fetch_instr, NOP);
  endtask

  initial begin
    rst_n      = 1'b0;
    ld_start   = 1'b0;
    ld_valid   = 1'b0;
    ld_byte    = 8'd0;
    fetch_addr = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good two-word program
    progWords = '{32'h0050_0093, 32'h00A0_0113};
    loadProgram(8'd0);
    checkOutput("goodCoreRst", {31'd0, core_rst_n}, 32'd1);
    checkOutput("goodDone", {31'd0, load_done}, 32'd1);
    checkOutput("goodWords", {16'd0, words_loaded}, 32'd2);
    checkOutput("goodReady", {31'd0, ld_ready}, 32'd0);
    probeFetch("good0", 32'd0, 32'h0050_0093, 1'b0);
    probeFetch("good4", 32'd4, 32'h00A0_0113, 1'b0);
    probeFetch("good8", 32'd8, NOP, 1'b1);
    probeFetch("misaligned2", 32'd2, NOP, 1'b1);

    // Same program with a corrupted checksum
    loadProgram(8'd1);
    checkOutput("badErr", {31'd0, load_err}, 32'd1);
    checkOutput("badDone", {31'd0, load_done}, 32'd0);
    checkOutput("badCoreRst", {31'd0, core_rst_n}, 32'd0);
    checkOutput("badWords", {16'd0, words_loaded}, 32'd0);
    probeFetch("bad0", 32'd0, NOP, 1'b1);
    probeFetch("bad4", 32'd4, NOP, 1'b1);

    // Oversize length: 257 words into a 256-word memory
    pulseStart();
    checkOutput("bigStartReady", {31'd0, ld_ready}, 32'd1);
    checkOutput("bigStartErr", {31'd0, load_err}, 32'd0);
    applyStimulus(8'h01);
    applyStimulus(8'h01);
    checkOutput("bigErr", {31'd0, load_err}, 32'd1);
    checkOutput("bigReady", {31'd0, ld_ready}, 32'd0);
    checkOutput("bigWords", {16'd0, words_loaded}, 32'd0);
    checkOutput("bigCoreRst", {31'd0, core_rst_n}, 32'd0);

    // Empty program
    progWords.delete();
    loadProgram(8'd0);
    checkOutput("emptyDone", {31'd0, load_done}, 32'd1);
    checkOutput("emptyCoreRst", {31'd0, core_rst_n}, 32'd1);
    checkOutput("emptyWords", {16'd0, words_loaded}, 32'd0);
    probeFetch("empty0", 32'd0, NOP, 1'b1);

    // Abort mid-data with a byte offered in the same cycle as ld_start
    pulseStart();
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(8'hA0 + 8'(i));
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'h55;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    checkOutput("abortReady", {31'd0, ld_ready}, 32'd1);
    checkOutput("abortDone", {31'd0, load_done}, 32'd0);
    checkOutput("abortCoreRst", {31'd0, core_rst_n}, 32'd0);
    // Continue in LEN_LO with a fresh single-word program
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'hEF);
    applyStimulus(8'hBE);
    applyStimulus(8'hAD);
    applyStimulus(8'hDE);
    applyStimulus(8'h38);
    checkOutput("reloadDone", {31'd0, load_done}, 32'd1);
    checkOutput("reloadWords", {16'd0, words_loaded}, 32'd1);
    probeFetch("reload0", 32'd0, 32'hDEAD_BEEF, 1'b0);
    probeFetch("reload4", 32'd4, NOP, 1'b1);
    probeFetch("reloadMis", 32'd2, NOP, 1'b1);

    // Asynchronous reset in the middle of a data word
    pulseStart();
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    #2;
    rst_n = 1'b0;
    checkResetValues("midReset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkResetValues("afterReset");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Instruction-memory responder for the 5-stage core's fetch port. It serves the core's PC with a same-cycle 32-bit instruction and holds the core in reset until a program has been loaded. Programs arrive over a byte-serial valid/ready load stream from the host link (UART bridge or testbench). The block sits between the host link and the core's `pc_out`/`instr_in` pair, and owns the core's reset.

## Interface
- `DEPTH` — default 256 — instruction memory size in 32-bit words; power of two, 2..65536.
- `clk`  in  1  — clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `ld_start`  in  1  — single-cycle pulse; aborts any load in progress and begins a new one.
- `ld_valid`  in  1  — a load byte is present on `ld_byte`.
- `ld_byte`  in  8  — load stream data.
- `ld_ready`  out  1  — the block can accept a byte this cycle.
- `fetch_addr`  in  32  — byte address from the core PC.
- `fetch_instr`  out  32  — instruction at `fetch_addr`.
- `fetch_err`  out  1  — `fetch_addr` is misaligned or beyond the loaded program.
- `core_rst_n`  out  1  — active-low reset to the core; registered.
- `load_done`  out  1  — the program is loaded and its checksum matched.
- `load_err`  out  1  — the last load failed (oversize length or checksum mismatch).
- `words_loaded`  out  16  — word count N of the last successful load.

## Operation
- Stream format: LEN_LO, LEN_HI (N, a 16-bit little-endian word count), then 4·N data bytes with each word little-endian, then 1 checksum byte.
- Checksum byte = sum of all 4·N data bytes mod 256. Length bytes are excluded.
- Byte accept = `ld_valid & ld_ready & ~ld_start`. `ld_start` always wins; a byte offered in the same cycle is dropped.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- `ld_ready` = 1 only in LEN_LO, LEN_HI, DATA and CSUM. It is decoded combinationally from state.
- Transitions:
  - `ld_start` from any state → LEN_LO. This clears `load_done`, `load_err` and the running sum, and drives `core_rst_n` low.
  - LEN_LO, on accept → LEN_HI.
  - LEN_HI, on accept:
    - N > DEPTH → ERR.
    - N = 0 → CSUM.
    - otherwise → DATA.
  - DATA: a 2-bit byte counter assembles bytes into a word. On the 4th byte the word is written to `mem[word_idx]`, the counter wraps to 0 and `word_idx` increments. After word N−1 is written → CSUM.
  - CSUM, on accept: byte equals the running sum → DONE; otherwise → ERR.
  - DONE and ERR stay put until the next `ld_start` or reset.
- On entry to DONE: `words_loaded` ← N and `load_done` ← 1.
- On entry to ERR: `load_err` ← 1 and `words_loaded` ← 0.
- `core_rst_n` = 1 only in DONE. A new `ld_start` re-asserts core reset the next cycle.
- Fetch path is combinational. With `idx = fetch_addr[31:2]`:
  - `fetch_instr` = `mem[idx]` when `fetch_addr[1:0] == 0`, `idx < words_loaded` and `load_done` = 1.
  - Otherwise `fetch_instr` = 32'h00000013 (NOP) and `fetch_err` = 1.
- While a load is in progress, fetch returns NOP. The core is in reset during a load, so it does not observe this.
- Memory contents are not reset. Words at index ≥ N keep stale data but are never served.
- Arithmetic widths: running sum 8 bits, wraps; `word_idx` 16 bits. The N ≤ DEPTH check is done on the full 16-bit N before any write.

## Timing
- Reset values: state IDLE, `ld_ready` 0, `core_rst_n` 0, `load_done` 0, `load_err` 0, `words_loaded` 0, `fetch_err` 1, `fetch_instr` 32'h00000013.
- State, counters, sum and status outputs update on the `clk` rising edge following the accept or `ld_start`.
- The memory write happens on the edge that accepts the 4th byte of a word. The written word can be fetched only after DONE is reached.
- `core_rst_n` rises on the same edge that enters DONE, which is the edge accepting the checksum byte.
- Fetch latency is 0 cycles (combinational from `fetch_addr` and the memory array).
- Mid-load `rst_n` assertion returns the block to IDLE immediately and asynchronously; the partially written memory is ignored.
- `ld_start` during DATA aborts the load. Words already written stay in memory but are not served until a successful reload.
- Back-to-back accepts every cycle are supported: a full load takes 2 + 4N + 1 accepted bytes.

## Test plan
- Load N=2 with words 0x00500093 and 0x00A00113 and a correct checksum. Then:
  - `core_rst_n` goes to 1 on the edge after the checksum byte.
  - `fetch_addr`=0 → 0x00500093.
  - `fetch_addr`=4 → 0x00A00113.
  - `fetch_addr`=8 → NOP with `fetch_err`=1.
- Same load with checksum byte +1 → ERR: `load_err`=1, `core_rst_n`=0, `words_loaded`=0, and every fetch returns 0x00000013.
- DEPTH=256, length bytes 0x01,0x01 (N=257) → ERR immediately after LEN_HI. `ld_ready` drops to 0 and no memory write occurs.
- N=0 followed by checksum 0x00 → DONE with `words_loaded`=0. Every fetch returns NOP with `fetch_err`=1.
- Abort/restart sequence:
  - Start a load, then pulse `ld_start` after 5 data bytes, with `ld_valid`=1 in the same cycle. The byte is dropped and the state is LEN_LO.
  - A fresh N=1 load of 0xDEADBEEF then serves 0xDEADBEEF at address 0.
- Misaligned fetch (`fetch_addr`=2) after a valid load → NOP and `fetch_err`=1.
- `rst_n` pulsed mid-DATA → all outputs return to reset values.
